// File: rtl/secure_core_pkg.sv
// Shared types and helpers for the keyed rotate-XOR scrambling core sequencer.
// Holds the FSM encoding, dbg_status field layout and the round function.
package secure_core_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RUN     = 4'd1,
        ST_DONE    = 4'd2,
        ST_ZEROIZE = 4'd3,
        ST_DEBUG   = 4'd4
    } seq_state_e;

    localparam int unsigned DBG_RCNT_LSB  = 0;
    localparam int unsigned DBG_RCNT_W    = 8;
    localparam int unsigned DBG_STATE_LSB = 8;
    localparam int unsigned DBG_STATE_W   = 4;

    function automatic logic [31:0] rot16_xor(input logic [31:0] state, input logic [31:0] key);
        return {state[15:0], state[31:16]} ^ key;
    endfunction

endpackage

// File: rtl/secure_round_unit.sv
// Key and state storage plus one scrambling round per step.
// clear dominates load, which dominates step, so zeroization can never be skipped.
module secure_round_unit
    import secure_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        clear_i,
    input  logic [31:0] key_i,
    input  logic [31:0] data_i,
    output logic [31:0] state_o
);

    logic [31:0] key_q, key_d;
    logic [31:0] state_q, state_d;

    always_comb begin
        key_d   = key_q;
        state_d = state_q;
        if (clear_i) begin
            key_d   = '0;
            state_d = '0;
        end else if (load_i) begin
            key_d   = key_i;
            state_d = data_i ^ key_i;
        end else if (step_i) begin
            state_d = rot16_xor(state_q, key_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            state_q <= '0;
        end else begin
            key_q   <= key_d;
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/secure_core_sequencer.sv
// Arbitrates the scrambling core between host and debug, sequences rounds and
// zeroizes key/state after each operation. Debug sees only FSM state and round count.
module secure_core_sequencer
    import secure_core_pkg::*;
#(
    parameter int unsigned ROUNDS        = 8,
    parameter int unsigned DBG_MIN_LEVEL = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_key,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    input  logic        abort,
    input  logic        dbg_req,
    input  logic        dbg_unlock,
    input  logic [3:0]  dbg_level,
    output logic        dbg_gnt,
    output logic [31:0] dbg_status,
    output logic        busy
);

    seq_state_e  fsm_q;
    logic [7:0]  round_cnt_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        dbg_gnt_q;
    logic        busy_q;

    logic        dbg_ok;
    logic        accept;
    logic        abort_op;
    logic        rsp_hs;
    logic        last_round;
    logic        rnd_load;
    logic        rnd_step;
    logic        rnd_clear;
    logic [31:0] core_state;

    assign dbg_ok     = dbg_req && dbg_unlock && ({28'b0, dbg_level} >= 32'(DBG_MIN_LEVEL));
    // req_ready_q gates acceptance so the first cycle after reset cannot take a request.
    assign accept     = (fsm_q == ST_IDLE) && req_ready_q && req_valid;
    assign abort_op   = ((fsm_q == ST_RUN) || (fsm_q == ST_DONE)) && abort;
    assign rsp_hs     = (fsm_q == ST_DONE) && rsp_ready;
    assign last_round = (round_cnt_q == 8'(ROUNDS - 1));

    assign rnd_load   = accept;
    assign rnd_step   = (fsm_q == ST_RUN) && !abort;
    assign rnd_clear  = (fsm_q == ST_ZEROIZE) || abort_op || rsp_hs;

    secure_round_unit u_round (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (rnd_load),
        .step_i  (rnd_step),
        .clear_i (rnd_clear),
        .key_i   (req_key),
        .data_i  (req_data),
        .state_o (core_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            round_cnt_q <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            dbg_gnt_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (accept) begin
                        fsm_q       <= ST_RUN;
                        round_cnt_q <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end else if (dbg_ok) begin
                        fsm_q       <= ST_DEBUG;
                        req_ready_q <= 1'b0;
                        dbg_gnt_q   <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        fsm_q       <= ST_ZEROIZE;
                        round_cnt_q <= '0;
                    end else begin
                        round_cnt_q <= round_cnt_q + 8'd1;
                        if (last_round) begin
                            fsm_q       <= ST_DONE;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (abort || rsp_ready) begin
                        fsm_q       <= ST_ZEROIZE;
                        round_cnt_q <= '0;
                        rsp_valid_q <= 1'b0;
                    end
                end
                ST_ZEROIZE: begin
                    fsm_q       <= ST_IDLE;
                    round_cnt_q <= '0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                ST_DEBUG: begin
                    if (!dbg_ok) begin
                        fsm_q       <= ST_IDLE;
                        dbg_gnt_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    fsm_q       <= ST_ZEROIZE;
                    round_cnt_q <= '0;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    dbg_gnt_q   <= 1'b0;
                    busy_q      <= 1'b1;
                end
            endcase
        end
    end

    // Only FSM state and round count reach the debug path; key/state never do.
    always_comb begin
        dbg_status = '0;
        if (dbg_gnt_q) begin
            dbg_status[DBG_STATE_LSB +: DBG_STATE_W] = fsm_q;
            dbg_status[DBG_RCNT_LSB +: DBG_RCNT_W]   = round_cnt_q;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_valid_q ? core_state : '0;
    assign dbg_gnt   = dbg_gnt_q;
    assign busy      = busy_q;

endmodule

// File: doc/secure_core_sequencer.md
# secure_core_sequencer

Controller for the keyed rotate-XOR scrambling core. It arbitrates the core between a host request port and a debug port, and sequences a fixed number of scrambling rounds per host request. It zeroizes the key and state after every operation. The debug port sees only FSM status and never key or datapath state. It sits between the host bus adapter and the debug/JTAG status path, and replaces direct debug visibility of the core's internal state.

## Interface
Parameters:
- ROUNDS, 8, scrambling rounds per request (1..255).
- DBG_MIN_LEVEL, 3, minimum dbg_level for a debug grant.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  sequencer can accept a request.
- req_key  in  32  per-request secret key.
- req_data  in  32  plaintext word.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  host accepts the result.
- rsp_data  out  32  scrambled word; zero when rsp_valid=0.
- abort  in  1  cancel the in-flight operation.
- dbg_req  in  1  debug access request (level).
- dbg_unlock  in  1  debug authorization from lifecycle logic.
- dbg_level  in  4  requested debug level.
- dbg_gnt  out  1  debug access granted.
- dbg_status  out  32  {20'b0, state[3:0], round_cnt[7:0]} while dbg_gnt=1, else 0.
- busy  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, RUN, DONE, ZEROIZE, DEBUG.
- dbg_ok = dbg_req & dbg_unlock & (dbg_level >= DBG_MIN_LEVEL).
- IDLE:
  - req_ready = 1.
  - On req_valid, capture key_reg = req_key and state = req_data ^ req_key, clear round_cnt, and go to RUN.
  - Else if dbg_ok, go to DEBUG.
  - The host has fixed priority when both request in the same cycle.
- RUN: each cycle, state = {state[15:0], state[31:16]} ^ key_reg and round_cnt += 1. After the round where round_cnt was ROUNDS-1, go to DONE.
- DONE: rsp_valid = 1 and rsp_data = state, both held stable until rsp_ready. On rsp_valid & rsp_ready, go to ZEROIZE.
- ZEROIZE: key_reg, state and round_cnt are cleared to 0. The next state is IDLE unconditionally.
- DEBUG:
  - dbg_gnt = 1 and req_ready = 0. key_reg and state are already zero.
  - Return to IDLE in the first cycle dbg_ok is false.
- abort: in RUN or DONE, go to ZEROIZE the next cycle with no response. In DONE the pending rsp_valid drops. abort is ignored in IDLE, ZEROIZE and DEBUG.
- Key and state are never routed to dbg_status in any state.

## Timing
- Reset values: req_ready=0 during reset and 1 after reset release (IDLE); rsp_valid=0, rsp_data=0, dbg_gnt=0, dbg_status=0, busy=0. All internal registers are 0.
- Accept latency: request accepted on edge E0; rsp_valid is high after edge E0+ROUNDS.
- After the response handshake edge: ZEROIZE for one cycle, then req_ready=1 on the second cycle. The minimum issue interval is ROUNDS+3 cycles.
- dbg_gnt rises one cycle after dbg_ok is sampled in IDLE and falls one cycle after dbg_ok drops.
- Outputs are registered or decoded from the FSM state only, with no combinational path from inputs to outputs.
- Reset asserted mid-operation clears everything immediately. No response is issued afterwards.
- A req_valid held during DEBUG is accepted in IDLE on the cycle after DEBUG exits.
- A dbg_ok arriving during RUN or DONE waits. It is granted only after ZEROIZE, unless a host request wins in IDLE.

## Structure
- Package secure_core_pkg holds:
  - the state enum (4-bit encoding IDLE=0, RUN=1, DONE=2, ZEROIZE=3, DEBUG=4);
  - the dbg_status field offsets;
  - the function rot16_xor(state, key).
- Sub-module secure_round_unit holds key_reg, state and the round logic. Its controls are load, step and clear; its output is state. The FSM, round counter and arbitration stay in the top module.

## Test plan
- Host basic: ROUNDS=8, key=0x00000001, data=0x00000000 → rsp_valid 8 cycles after accept, rsp_data=0x00000001. Then ZEROIZE, with state=0.
- Identity: key=0x00000000, data=0x12345678, ROUNDS=8 → rsp_data=0x12345678. ROUNDS=1, key=0x00000001, data=0 → 0x00010001.
- Backpressure and abort:
  - rsp_ready low for 5 cycles → rsp_data is stable and held.
  - abort in RUN cycle 3 → no rsp_valid; req_ready returns 2 cycles later.
- Debug gating:
  - dbg_level=2 with unlock=1 → no grant.
  - dbg_level=3 with unlock=0 → no grant.
  - dbg_level=3 with unlock=1 → dbg_gnt, and dbg_status shows state 4 with key bits never visible.
- Collision: req_valid and dbg_ok in the same IDLE cycle → host is served first; dbg_gnt is asserted after ZEROIZE.
- Reset mid-RUN: deassert rst_n → all outputs are 0 immediately; after release, a new request produces the correct result.
